traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 95 +++++++++
 tb/tb_traffic_light_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - observes a highway/country-road light pair and flags illegal,
// conflicting, out-of-sequence, short-yellow and starvation behaviour with latency 1.
module traffic_light_monitor #(
  parameter int Y_MIN    = 3,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       highway,
  input  logic [1:0]       country_road,
  input  logic             x,
  input  logic             clr,
  output logic [4:0]       err_flags,
  output logic             err_pulse,
  output logic [CNT_W-1:0] viol_count
);
  typedef enum logic [1:0] {RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10} light_e;

  localparam logic [3:0] Y_MIN4  = 4'(Y_MIN);
  localparam logic [7:0] MAX_W8  = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  light_e           hw_q, hw_d, cr_q, cr_d;
  logic [3:0]       hy_q, hy_d, cy_q, cy_d;
  logic [7:0]       wait_q, wait_d;
  logic [4:0]       flags_q, flags_d, fire;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             h_ill, h_seq, h_ysh, c_ill, c_seq, c_ysh;
  logic             conflict, wait_inc, starve;

  // Illegal codes leave the tracker and its yellow counter untouched.
  function automatic void road_step(input logic [1:0] v, input light_e st, input logic [3:0] yc,
                                    output light_e st_n, output logic [3:0] yc_n,
                                    output logic ill, output logic seq, output logic ysh);
    ill  = 1'b0;
    seq  = 1'b0;
    ysh  = 1'b0;
    st_n = st;
    yc_n = yc;
    if (v == 2'b11) begin
      ill = 1'b1;
    end else begin
      st_n = light_e'(v);
      if (st_n != st) begin
        seq = !((st == RED && st_n == GREEN) || (st == GREEN && st_n == YELLOW) ||
                (st == YELLOW && st_n == RED));
        ysh = (st == YELLOW) && (st_n == RED) && (yc < Y_MIN4);
      end
      if (st_n == YELLOW) yc_n = (st != YELLOW) ? 4'd1 : ((yc < Y_MIN4) ? yc + 4'd1 : yc);
      else                yc_n = 4'd0;
    end
  endfunction

  always_comb begin
    road_step(highway, hw_q, hy_q, hw_d, hy_d, h_ill, h_seq, h_ysh);
    road_step(country_road, cr_q, cy_q, cr_d, cy_d, c_ill, c_seq, c_ysh);
    conflict = (highway == 2'b01 || highway == 2'b10) &&
               (country_road == 2'b01 || country_road == 2'b10);
    wait_inc = x && (country_road != 2'b10);
    starve   = wait_inc && (wait_q == MAX_W8 - 8'd1);
    wait_d   = !wait_inc ? 8'd0 : ((wait_q < MAX_W8) ? wait_q + 8'd1 : wait_q);
    fire     = {starve, h_ysh | c_ysh, h_seq | c_seq, conflict, h_ill | c_ill};
    flags_d  = clr ? fire : (flags_q | fire);
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = ((|fire) && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_q    <= RED;
      cr_q    <= RED;
      hy_q    <= 4'd0;
      cy_q    <= 4'd0;
      wait_q  <= 8'd0;
      flags_q <= 5'd0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hw_q    <= hw_d;
      cr_q    <= cr_d;
      hy_q    <= hy_d;
      cy_q    <= cy_d;
      wait_q  <= wait_d;
      flags_q <= flags_d;
      pulse_q <= |fire;
      cnt_q   <= cnt_d;
    end
  end

  assign err_flags  = flags_q;
  assign err_pulse  = pulse_q;
  assign viol_count = cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor.
module tb_traffic_light_monitor;
  localparam int Y_MIN    = 3;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 8;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]       f;
    logic             p;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       highway = 2'b00;
  logic [1:0]       country_road = 2'b00;
  logic             x = 1'b0;
  logic             clr = 1'b0;
  logic [4:0]       err_flags;
  logic             err_pulse;
  logic [CNT_W-1:0] viol_count;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: road history as plain integers and unbounded run lengths.
  int         m_last[2];
  int         m_yrun[2];
  int         m_wait;
  logic [4:0] m_flags;
  int         m_cnt;
  int         drv[2];

  traffic_light_monitor #(.Y_MIN(Y_MIN), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .highway(highway), .country_road(country_road), .x(x), .clr(clr),
    .err_flags(err_flags), .err_pulse(err_pulse), .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  function automatic bit legal_move(int a, int b);
    return (a == b) || (a == 0 && b == 2) || (a == 2 && b == 1) || (a == 1 && b == 0);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 2; r++) begin
      m_last[r] = 0;
      m_yrun[r] = 0;
      drv[r]    = 0;
    end
    m_wait  = 0;
    m_flags = 5'd0;
    m_cnt   = 0;
  endfunction

  task automatic check_zero(input string name);
    n_cmp++;
    if (err_flags !== 5'd0 || err_pulse !== 1'b0 || viol_count !== '0) begin
      n_bad++;
      $display("FAIL %s: flags=%b pulse=%b count=%0d, required all zero",
               name, err_flags, err_pulse, viol_count);
    end
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] c, input logic xv, input logic cv);
    int         v[2];
    logic [4:0] f;
    int         base;
    exp_t       e;
    @(negedge clk);
    highway      = h;
    country_road = c;
    x            = xv;
    clr          = cv;
    v[0] = int'(h);
    v[1] = int'(c);
    f    = 5'd0;
    for (int r = 0; r < 2; r++) begin
      if (v[r] == 3) begin
        f[0] = 1'b1;
      end else begin
        if (!legal_move(m_last[r], v[r])) f[2] = 1'b1;
        if (m_last[r] == 1 && v[r] == 0 && m_yrun[r] < Y_MIN) f[3] = 1'b1;
        m_yrun[r] = (v[r] == 1) ? ((m_last[r] == 1) ? m_yrun[r] + 1 : 1) : 0;
        m_last[r] = v[r];
      end
    end
    if ((v[0] == 1 || v[0] == 2) && (v[1] == 1 || v[1] == 2)) f[1] = 1'b1;
    if (xv && v[1] != 2) begin
      m_wait++;
      if (m_wait == MAX_WAIT) f[4] = 1'b1;
    end else begin
      m_wait = 0;
    end
    m_flags = cv ? f : (m_flags | f);
    base    = cv ? 0 : m_cnt;
    if (|f) base = (base + 1 > CNT_TOP) ? CNT_TOP : base + 1;
    m_cnt = base;
    e.f = m_flags;
    e.p = |f;
    e.c = CNT_W'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    highway      = 2'b00;
    country_road = 2'b00;
    x            = 1'b0;
    clr          = 1'b0;
    rst          = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    exp_q.delete();
    model_reset();
    rst = 1'b0;
  endtask

  // Monitor: the DUT presents a result every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (err_flags !== e.f || err_pulse !== e.p || viol_count !== e.c) begin
          n_bad++;
          $display("FAIL outputs @%0t: flags=%b pulse=%b count=%0d, required flags=%b pulse=%b count=%0d",
                   $time, err_flags, err_pulse, viol_count, e.f, e.p, e.c);
        end
      end
    end
  end

  initial begin
    int nv;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Full legal cycle.
    step(2'b10, 2'b00, 1'b0, 1'b0);
    repeat (3) step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    repeat (5) step(2'b00, 2'b10, 1'b1, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);

    // Conflict then illegal.
    do_reset();
    step(2'b10, 2'b01, 1'b0, 1'b0);
    step(2'b11, 2'b01, 1'b0, 1'b0);

    // Short yellow.
    do_reset();
    step(2'b10, 2'b00, 1'b0, 1'b0);
    repeat (2) step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);

    // Starvation.
    do_reset();
    repeat (20) step(2'b00, 2'b00, 1'b1, 1'b0);

    // Saturation then clear.
    do_reset();
    repeat (300) step(2'b10, 2'b01, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0, 1'b1);
    step(2'b10, 2'b00, 1'b0, 1'b0);

    // Reset mid-yellow.
    do_reset();
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    do_reset();
    step(2'b00, 2'b00, 1'b0, 1'b0);

    // Randomised walk: mostly legal progressions with occasional arbitrary codes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        nv = int'($urandom_range(0, 99));
        if (nv < 8)       drv[r] = int'($urandom_range(0, 3));
        else if (nv < 40) drv[r] = (drv[r] == 0) ? 2 : (drv[r] == 2) ? 1 : 0;
        else if (drv[r] == 3) drv[r] = 0;
      end
      if ($urandom_range(0, 999) < 3) do_reset();
      else step(2'(drv[0]), 2'(drv[1]), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
